// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// imem_boot_loader_if : byte-stream handshake and instruction-memory write port
// Revision 1.0
// ============================================================================
interface imem_boot_loader_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;
   logic             imem_we;
   logic [AW-1:0]    imem_addr;
   logic [WIDTH-1:0] imem_wdata;

   // The loader drives the memory write port and the stream's ready
   modport master (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// imem_boot_loader : packs a checksummed byte stream into instruction words
// Revision 1.0
// ============================================================================
module imem_boot_loader #(
   parameter int WIDTH       = 32,
   parameter int WORD_LENGTH = 32
) (
   input  wire logic                 clk,
   input  wire logic                 rst_n,
   input  wire logic                 start_i,
   imem_boot_loader_if.master        bus,
   output logic                      core_rst_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o
);
   localparam int C_BYTES = WIDTH / 8;
   localparam int C_AW    = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
   localparam int C_BIW   = (C_BYTES > 1) ? $clog2(C_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_CSUM  = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         n_q, n_d;
   logic [7:0]         xor_q, xor_d;
   logic [C_BIW-1:0]   byte_idx_q, byte_idx_d;
   logic [7:0]         word_idx_q, word_idx_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic [C_AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;

   logic               w_ready;
   logic               w_accept;
   logic [WIDTH-1:0]   w_word_ins;
   logic [7:0]         w_word_idx_inc;
   logic               w_hdr_bad;

   assign w_ready        = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign w_accept       = w_ready & bus.byte_valid;
   assign w_word_idx_inc = word_idx_q + 8'd1;
   assign w_hdr_bad      = (bus.byte_data == 8'd0) ||
                           ({1'b0, bus.byte_data} > 9'(WORD_LENGTH));

   // Little-endian insertion of the incoming byte at the current byte slot
   always_comb begin
      w_word_ins = word_q;
      w_word_ins[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         xor_q      <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         word_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         xor_q      <= xor_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      xor_d      = xor_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_HDR;
         end
         S_HDR: begin
            if (w_accept) begin
               n_d        = bus.byte_data;
               xor_d      = bus.byte_data;
               byte_idx_d = '0;
               word_idx_d = '0;
               word_d     = '0;
               state_d    = w_hdr_bad ? S_ERR : S_DATA;
            end
         end
         S_DATA: begin
            if (w_accept) begin
               xor_d  = xor_q ^ bus.byte_data;
               word_d = w_word_ins;
               if (byte_idx_q == C_BIW'(C_BYTES - 1)) begin
                  // Latch the write port on the final byte so it holds after WRITE
                  addr_d     = word_idx_q[C_AW-1:0];
                  wdata_d    = w_word_ins;
                  byte_idx_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_idx_d = byte_idx_q + C_BIW'(1);
               end
            end
         end
         S_WRITE: begin
            word_idx_d = w_word_idx_inc;
            word_d     = '0;
            state_d    = (w_word_idx_inc == n_q) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (w_accept) state_d = (bus.byte_data == xor_q) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (start_i) state_d = S_HDR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.byte_ready = w_ready;
   assign bus.imem_we    = (state_q == S_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_rst_o     = (state_q != S_DONE);
   assign busy_o         = (state_q == S_HDR) || (state_q == S_DATA) ||
                           (state_q == S_WRITE) || (state_q == S_CSUM);
   assign done_o         = (state_q == S_DONE);
   assign error_o        = (state_q == S_ERR);
endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_boot_loader : scoreboard bench for imem_boot_loader
// Revision 1.0
// ============================================================================
module tb_imem_boot_loader;
   localparam int WIDTH = 32;
   localparam int WL    = 32;
   localparam int AW    = 5;

   logic clk;
   logic rst_n;
   logic start_i;
   logic core_rst_o, busy_o, done_o, error_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } wr_t;
   wr_t exp_q[$];

   imem_boot_loader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   imem_boot_loader #(.WIDTH(WIDTH), .WORD_LENGTH(WL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .bus        (bus),
      .core_rst_o (core_rst_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .error_o    (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && bus.imem_we) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr=%0d data=%08h, none expected",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr=%0d data=%08h, expected addr=%0d data=%08h",
                        bus.imem_addr, bus.imem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      bit ok;
      ok = 1'b0;
      repeat (idle) begin
         bus.byte_valid = 1'b0;
         @(negedge clk);
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      for (int t = 0; t < 50; t++) begin
         if (bus.byte_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL byte_timeout: byte %02h never accepted", b);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s[], input int idle);
      foreach (s[i]) send_byte(s[i], idle);
   endtask

   task automatic push_two_words();
      exp_q.push_back('{addr: 5'd0, data: 32'h1234_5678});
      exp_q.push_back('{addr: 5'd1, data: 32'hDEAD_BEEF});
   endtask

   task automatic check_status(input string tag, input logic c, input logic b,
                               input logic d, input logic e);
      check({tag, "_core_rst"}, 32'(core_rst_o), 32'(c));
      check({tag, "_busy"},     32'(busy_o),     32'(b));
      check({tag, "_done"},     32'(done_o),     32'(d));
      check({tag, "_error"},    32'(error_o),    32'(e));
   endtask

   logic [7:0] good_stream[] = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
   logic [7:0] bad_stream[]  = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};

   initial begin
      rst_n          = 1'b0;
      start_i        = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      repeat (3) @(negedge clk);

      // Reset values
      check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      check("reset_ready", 32'(bus.byte_ready), 32'd0);
      check("reset_we",    32'(bus.imem_we),    32'd0);
      check("reset_addr",  32'(bus.imem_addr),  32'd0);
      check("reset_wdata", bus.imem_wdata,      32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_status("idle", 1'b1, 1'b0, 1'b0, 1'b0);

      // Good two-word load, back-to-back
      pulse_start();
      check_status("hdr", 1'b1, 1'b1, 1'b0, 1'b0);
      check("hdr_ready", 32'(bus.byte_ready), 32'd1);
      push_two_words();
      send_stream(good_stream, 0);
      check_status("good_done", 1'b0, 1'b0, 1'b1, 1'b0);
      check("held_addr",  32'(bus.imem_addr), 32'd1);
      check("held_wdata", bus.imem_wdata,     32'hDEAD_BEEF);

      // Restart from DONE, wrong checksum
      pulse_start();
      check_status("restart", 1'b1, 1'b1, 1'b0, 1'b0);
      push_two_words();
      send_stream(bad_stream, 0);
      check_status("bad_csum", 1'b1, 1'b0, 1'b0, 1'b1);

      // Header 0x00 and 0x21 both rejected, no writes
      pulse_start();
      check_status("from_err", 1'b1, 1'b1, 1'b0, 1'b0);
      send_byte(8'h00, 0);
      check_status("hdr_zero", 1'b1, 1'b0, 1'b0, 1'b1);
      pulse_start();
      send_byte(8'h21, 0);
      check_status("hdr_big", 1'b1, 1'b0, 1'b0, 1'b1);

      // Gapped stream with a stray start mid-load
      pulse_start();
      push_two_words();
      for (int i = 0; i < 4; i++) send_byte(good_stream[i], 1);
      pulse_start();
      check("stray_start_busy", 32'(busy_o), 32'd1);
      for (int i = 4; i < 10; i++) send_byte(good_stream[i], 1);
      check_status("gapped_done", 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset after 3 data bytes of word 0, then a full load
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h78, 0);
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check_status("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_reset_ready", 32'(bus.byte_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      push_two_words();
      send_stream(good_stream, 0);
      check_status("reload_done", 1'b0, 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
